z80_intc_vec: RTL and testbench
===============================

# z80_intc_vec

Parametrised vectored interrupt controller for the Z80 side of the design. It collects up to NCH one-cycle request strobes from peripherals and gates them with per-channel enables. It drives `int_n`, and on the Z80 interrupt-acknowledge cycle it supplies a full IM2 vector byte for the highest-priority pending channel, then retires that request. An optional in-service register supports nested priority with explicit end-of-interrupt.

## Interface
- `NCH`, 8: channel count, 2..16. Channel 0 has the highest priority.
- `CW`, derived as clog2(NCH): channel index width.
- `VEC_BASE`, 8'h00: IM2 vector base. Bits [CW:0] must be 0.
- `ENA_RST`, 1 (NCH bits): reset value of the enable register.

Ports:
- `clk`  in  1  system clock; all logic on the posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `m1_n`  in  1  Z80 M1, asynchronous.
- `iorq_n`  in  1  Z80 IORQ, asynchronous.
- `int_stbs`  in  NCH  request strobes, one clk wide.
- `wr_mask`  in  NCH  selects the channels affected by a write.
- `wr_val`  in  1  value written to the selected bits.
- `ena_wr`  in  1  enable-register write strobe.
- `req_wr`  in  1  request-register write strobe.
- `eoi_wr`  in  1  end-of-interrupt strobe.
- `ena_rd`  out  NCH  enable readback.
- `req_rd`  out  NCH  request readback.
- `isr_rd`  out  NCH  in-service readback.
- `int_n`  out  1  interrupt to the Z80, registered.
- `int_vector`  out  8  IM2 vector byte.
- `int_ack`  out  1  one-clk pulse when a real request is retired.

## Operation
- **Synchronisers.** `m1_n` and `(iorq_n | m1_n)` each pass through a 2-flop synchroniser plus an edge flop.
  - `m1_beg` is the synchronised falling edge of `m1_n`.
  - `iack_end` is the synchronised rising edge of `(iorq_n | m1_n)`.
- **Eligible set.** `elig = req & ena & above`.
  - `above` is the set of channels whose index is lower than the lowest set bit of `isr`, or all ones when `isr` is 0.
- **int_n.** Registered each clk: `int_n <= ~|elig`.
- **Latch.** On `m1_beg`, latch `pidx` (lowest set index of `elig`) and `pval = |elig`. The latch holds until the next `m1_beg`.
- **int_vector.**
  - If `pval` is 1: `VEC_BASE | {pidx, 1'b0}`.
  - If `pval` is 0 (spurious): `VEC_BASE | {CW ones, 1'b0}`.
- **Acknowledge.** On `iack_end` with `pval` = 1:
  - clear `req[pidx]`;
  - pulse `int_ack`;
  - set `isr[pidx]`.
  - With `pval` = 0, `iack_end` does nothing.
- **Request priority per bit, highest first:**
  1. strobe sets the bit;
  2. ack clears it;
  3. `req_wr & wr_mask[i]` loads `wr_val`.
- **Enable writes.** `ena_wr & wr_mask[i]` loads `wr_val` into `ena[i]`.
- **End of interrupt.** `eoi_wr` clears the lowest set bit of `isr`. With `isr` = 0 it has no effect.
- **Simultaneous ack and EOI.** Both apply in the same cycle: the ack sets its bit and the EOI clears its bit.

## Timing
- **Reset values:**
  - `int_n` = 1, `int_ack` = 0;
  - `ena` = `ENA_RST`, `req` = 0, `isr` = 0;
  - `pval` = 0, `pidx` = 0;
  - `int_vector` = spurious value;
  - synchroniser flops = 1.
- **Reset mid-acknowledge.** Any pending `iack_end` is discarded. No request is retired.
- **Strobe to interrupt.** A strobe on edge t sets `req` at t+1. `int_n` falls at t+2 if the channel is eligible.
- **Enable write.** An `ena_wr` at edge t takes effect on `int_n` at t+2.
- **Pin to internal event.** `m1_n` or `iorq_n` edge to `m1_beg`/`iack_end`: 3 clk.
  - Requirement: clk ≥ 4× the Z80 clock, so that `pidx` is stable before the Z80 samples the data bus.
- **Deassertion.** `int_n` rises 1 clk after the ack retires the last eligible request.
- **Readbacks.** `req_rd`, `ena_rd` and `isr_rd` are direct register outputs with 0 latency.

## Configuration
- Macro: `Z80_INTC_NESTING_EN`.
- **Defined:**
  - the `isr` register exists;
  - `above` masks equal-priority and lower-priority channels;
  - `eoi_wr` is functional.
- **Undefined:**
  - `isr` is constant 0;
  - `isr_rd` = 0;
  - `above` = all ones;
  - `eoi_wr` is ignored.
  - Behaviour is then a plain N-channel prioritised controller.

## Test plan
Parameters NCH = 8, VEC_BASE = 8'hE0.
- **Basic request.** `ena` = 8'h14, strobe channel 4 → `int_n` = 0 two clk later. After the M1/IORQ cycle: `int_vector` = 8'hE8, `int_ack` pulses once, `req_rd` = 0, `int_n` = 1.
- **Priority.** `ena` = 8'hFF, strobes on channels 2 and 5 in the same clk → first ack vector 8'hE4, second ack vector 8'hEA.
- **Strobe beats ack.** Strobe on channel 3 in the same clk as the `iack_end` retiring channel 3 → `req[3]` stays 1 and `int_n` stays 0.
- **Spurious cycle.** Drop `ena` between `int_n` assertion and M1 → `int_vector` = 8'hEE, no `int_ack`, `req` unchanged.
- **Nesting (macro on).** Ack channel 5 → `isr_rd` = 8'h20.
  - A strobe on channel 6 keeps `int_n` = 1.
  - A strobe on channel 1 drives `int_n` = 0.
  - After two `eoi_wr`, channel 6 asserts `int_n`.
- **Reset.** Assert `rst` during the IORQ low phase → all outputs at reset values. The retired request count stays 0.

Source files
------------

// File: rtl/z80_intc_vec_if.sv
// Bus bundle for z80_intc_vec: Z80 pins, peripheral request strobes,
// register write strobes and readbacks. The controller takes the slave
// modport; the CPU/bench side takes the master modport.
interface z80_intc_vec_if #(
  parameter int NCH = 8
);

  // Z80 side
  logic           m1_n;
  logic           iorq_n;
  logic           int_n;
  logic [7:0]     int_vector;
  logic           int_ack;

  // Peripheral request strobes
  logic [NCH-1:0] int_stbs;

  // Register access
  logic [NCH-1:0] wr_mask;
  logic           wr_val;
  logic           ena_wr;
  logic           req_wr;
  logic           eoi_wr;
  logic [NCH-1:0] ena_rd;
  logic [NCH-1:0] req_rd;
  logic [NCH-1:0] isr_rd;

  modport master (
    output m1_n, iorq_n, int_stbs, wr_mask, wr_val, ena_wr, req_wr, eoi_wr,
    input  ena_rd, req_rd, isr_rd, int_n, int_vector, int_ack
  );

  modport slave (
    input  m1_n, iorq_n, int_stbs, wr_mask, wr_val, ena_wr, req_wr, eoi_wr,
    output ena_rd, req_rd, isr_rd, int_n, int_vector, int_ack
  );

endinterface

// File: rtl/z80_intc_vec.sv
// z80_intc_vec: vectored interrupt controller for the Z80 (IM2).
// Collects one-clk request strobes, gates them with per-channel enables,
// drives int_n and supplies the vector of the highest-priority pending
// channel (channel 0 highest) on the interrupt-acknowledge cycle.
//
// Optional feature: define Z80_INTC_NESTING_EN to add the in-service
// register (nested priority with explicit end-of-interrupt). Without it
// isr reads 0, every channel is above, and eoi_wr is ignored.
module z80_intc_vec #(
  parameter int             NCH      = 8,
  parameter logic [7:0]     VEC_BASE = 8'h00,
  parameter logic [NCH-1:0] ENA_RST  = '1
) (
  input  logic          clk,
  input  logic          rst,
  z80_intc_vec_if.slave bus
);

  localparam int CW = $clog2(NCH);

  // Vector returned when the acknowledge finds nothing eligible.
  localparam logic [7:0] VEC_SPUR = VEC_BASE | 8'({{CW{1'b1}}, 1'b0});

  // Pin synchronisers and edge flops
  logic m1_s1, m1_s2, m1_d;
  logic ia_s1, ia_s2, ia_d;
  logic m1_beg;
  logic iack_end;

  // Controller state
  logic [NCH-1:0] ena_q;
  logic [NCH-1:0] req_q;
  logic [NCH-1:0] isr_q;
  logic [CW-1:0]  pidx_q;
  logic           pval_q;
  logic           int_n_q;
  logic           int_ack_q;

  // Combinational next-state terms
  logic [NCH-1:0] above;
  logic [NCH-1:0] elig;
  logic [CW-1:0]  pidx_c;
  logic           pval_c;
  logic [NCH-1:0] ack_set;
  logic [NCH-1:0] req_nxt;
  logic [NCH-1:0] ena_nxt;

  // Two-flop synchronisers plus an edge flop for M1 and for IORQ|M1.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      {m1_s1, m1_s2, m1_d} <= 3'b111;
      {ia_s1, ia_s2, ia_d} <= 3'b111;
    end else begin
      m1_s1 <= bus.m1_n;
      m1_s2 <= m1_s1;
      m1_d  <= m1_s2;
      ia_s1 <= bus.iorq_n | bus.m1_n;
      ia_s2 <= ia_s1;
      ia_d  <= ia_s2;
    end
  end

  // M1 start is the falling edge of M1; the acknowledge ends when IORQ|M1 rises.
  assign m1_beg   = m1_d & ~m1_s2;
  assign iack_end = ~ia_d & ia_s2;

`ifdef Z80_INTC_NESTING_EN
  logic [NCH-1:0] isr_low;
  logic [NCH-1:0] isr_nxt;

  // Lowest in-service bit, the priority mask it implies, and the isr update.
  always_comb begin
    isr_low = isr_q & (~isr_q + NCH'(1));
    above   = (isr_q == '0) ? '1 : (isr_low - NCH'(1));
    isr_nxt = (isr_q | ack_set) & ~(bus.eoi_wr ? isr_low : '0);
  end

  // In-service register: the ack sets its channel, EOI retires the lowest.
  always_ff @(posedge clk) begin
    if (rst) begin
      isr_q <= '0;
    end else begin
      isr_q <= isr_nxt;
    end
  end
`else
  logic unused_eoi;

  assign isr_q      = '0;
  assign above      = '1;
  assign unused_eoi = bus.eoi_wr;
`endif

  // Eligible set, priority encode, acknowledge decode and register updates.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    elig   = req_q & ena_q & above;
    pval_c = |elig;

    // Scan from the top so the lowest set index wins.
    pidx_c = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (elig[i]) pidx_c = CW'(i);
    end

    ack_set = '0;
    if (iack_end && pval_q) ack_set[pidx_q] = 1'b1;

    // Per bit: strobe beats ack, ack beats a software write.
    for (int i = 0; i < NCH; i++) begin
      if (bus.int_stbs[i])                 req_nxt[i] = 1'b1;
      else if (ack_set[i])                 req_nxt[i] = 1'b0;
      else if (bus.req_wr && bus.wr_mask[i]) req_nxt[i] = bus.wr_val;
      else                                 req_nxt[i] = req_q[i];

      ena_nxt[i] = (bus.ena_wr && bus.wr_mask[i]) ? bus.wr_val : ena_q[i];
    end
  end

  // Request/enable registers, acknowledge latch and registered Z80 outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ena_q     <= ENA_RST;
      req_q     <= '0;
      pidx_q    <= '0;
      pval_q    <= 1'b0;
      int_n_q   <= 1'b1;
      int_ack_q <= 1'b0;
    end else begin
      ena_q     <= ena_nxt;
      req_q     <= req_nxt;
      int_n_q   <= ~pval_c;
      int_ack_q <= iack_end & pval_q;
      // The latch holds through the whole M1 cycle so the vector is stable
      // while the Z80 samples the data bus.
      if (m1_beg) begin
        pidx_q <= pidx_c;
        pval_q <= pval_c;
      end
    end
  end

  assign bus.int_n      = int_n_q;
  assign bus.int_ack    = int_ack_q;
  assign bus.int_vector = pval_q ? (VEC_BASE | 8'({pidx_q, 1'b0})) : VEC_SPUR;
  assign bus.ena_rd     = ena_q;
  assign bus.req_rd     = req_q;
  assign bus.isr_rd     = isr_q;

endmodule

// File: tb/tb_z80_intc_vec.sv
// Directed bench for z80_intc_vec with NCH = 8, VEC_BASE = 8'hE0,
// ENA_RST = 8'hA5. Inputs change and outputs are sampled on the falling
// clock edge. Covers both builds (Z80_INTC_NESTING_EN on or off).
module tb_z80_intc_vec;

  logic clk = 1'b0;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;

  z80_intc_vec_if #(.NCH(8)) bus ();

  z80_intc_vec #(
    .NCH      (8),
    .VEC_BASE (8'hE0),
    .ENA_RST  (8'hA5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_stb(input logic [7:0] v);
    bus.int_stbs = v;
    tick(1);
    bus.int_stbs = '0;
  endtask

  // sel 0: enable register, sel 1: request register
  task automatic write_reg(input bit sel, input logic [7:0] mask, input logic val);
    bus.wr_mask = mask;
    bus.wr_val  = val;
    if (sel) bus.req_wr = 1'b1;
    else     bus.ena_wr = 1'b1;
    tick(1);
    bus.ena_wr  = 1'b0;
    bus.req_wr  = 1'b0;
    bus.wr_mask = '0;
    bus.wr_val  = 1'b0;
  endtask

  task automatic set_ena(input logic [7:0] v);
    write_reg(1'b0, 8'hFF, 1'b0);
    write_reg(1'b0, v, 1'b1);
  endtask

  task automatic eoi_pulse();
    bus.eoi_wr = 1'b1;
    tick(1);
    bus.eoi_wr = 1'b0;
  endtask

  task automatic clear_all();
    write_reg(1'b1, 8'hFF, 1'b0);
    repeat (8) eoi_pulse();
    tick(2);
  endtask

  // Full M1/IORQ acknowledge cycle. late_stb is applied on the clock where
  // the synchronised acknowledge end is acted on.
  task automatic iack_cycle(input logic [7:0] late_stb, output logic [7:0] vec,
                            output int acks);
    bus.m1_n = 1'b0;
    tick(3);
    bus.iorq_n = 1'b0;
    tick(1);
    vec = bus.int_vector;
    tick(1);
    bus.m1_n   = 1'b1;
    bus.iorq_n = 1'b1;
    tick(2);
    bus.int_stbs = late_stb;
    tick(1);
    bus.int_stbs = '0;
    acks = bus.int_ack ? 1 : 0;
    repeat (3) begin
      tick(1);
      if (bus.int_ack) acks++;
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (bus.int_n !== 1'b1) begin
      $display("FAIL reset_int_n: got %b want 1", bus.int_n); n_fail++;
    end
    n_tests++;
    if (bus.int_ack !== 1'b0) begin
      $display("FAIL reset_int_ack: got %b want 0", bus.int_ack); n_fail++;
    end
    n_tests++;
    if (bus.ena_rd !== 8'hA5) begin
      $display("FAIL reset_ena: got %h want a5", bus.ena_rd); n_fail++;
    end
    n_tests++;
    if (bus.req_rd !== 8'h00) begin
      $display("FAIL reset_req: got %h want 00", bus.req_rd); n_fail++;
    end
    n_tests++;
    if (bus.isr_rd !== 8'h00) begin
      $display("FAIL reset_isr: got %h want 00", bus.isr_rd); n_fail++;
    end
    n_tests++;
    if (bus.int_vector !== 8'hEE) begin
      $display("FAIL reset_vector: got %h want ee", bus.int_vector); n_fail++;
    end
  endtask

  task automatic test_basic();
    logic [7:0] vec;
    int acks;
    set_ena(8'h14);
    tick(2);
    n_tests++;
    if (bus.int_n !== 1'b1) begin
      $display("FAIL basic_idle_int_n: got %b want 1", bus.int_n); n_fail++;
    end
    pulse_stb(8'h10);
    n_tests++;
    if (bus.req_rd !== 8'h10 || bus.int_n !== 1'b1) begin
      $display("FAIL basic_req_t1: got req %h int_n %b want req 10 int_n 1",
               bus.req_rd, bus.int_n); n_fail++;
    end
    tick(1);
    n_tests++;
    if (bus.int_n !== 1'b0) begin
      $display("FAIL basic_int_n_t2: got %b want 0", bus.int_n); n_fail++;
    end
    iack_cycle(8'h00, vec, acks);
    n_tests++;
    if (vec !== 8'hE8) begin
      $display("FAIL basic_vector: got %h want e8", vec); n_fail++;
    end
    n_tests++;
    if (acks !== 1) begin
      $display("FAIL basic_ack_count: got %0d want 1", acks); n_fail++;
    end
    n_tests++;
    if (bus.req_rd !== 8'h00 || bus.int_n !== 1'b1) begin
      $display("FAIL basic_after_ack: got req %h int_n %b want req 00 int_n 1",
               bus.req_rd, bus.int_n); n_fail++;
    end
    clear_all();
  endtask

  task automatic test_priority();
    logic [7:0] vec;
    int acks;
    set_ena(8'hFF);
    pulse_stb(8'h24);
    tick(2);
    iack_cycle(8'h00, vec, acks);
    n_tests++;
    if (vec !== 8'hE4 || acks !== 1) begin
      $display("FAIL prio_first: got vec %h acks %0d want vec e4 acks 1", vec, acks);
      n_fail++;
    end
    n_tests++;
    if (bus.req_rd !== 8'h20) begin
      $display("FAIL prio_req_left: got %h want 20", bus.req_rd); n_fail++;
    end
    eoi_pulse();
    tick(2);
    iack_cycle(8'h00, vec, acks);
    n_tests++;
    if (vec !== 8'hEA || acks !== 1) begin
      $display("FAIL prio_second: got vec %h acks %0d want vec ea acks 1", vec, acks);
      n_fail++;
    end
    n_tests++;
    if (bus.req_rd !== 8'h00 || bus.int_n !== 1'b1) begin
      $display("FAIL prio_drained: got req %h int_n %b want req 00 int_n 1",
               bus.req_rd, bus.int_n); n_fail++;
    end
    clear_all();
  endtask

  task automatic test_strobe_beats_ack();
    logic [7:0] vec;
    int acks;
    set_ena(8'hFF);
    pulse_stb(8'h08);
    tick(2);
    iack_cycle(8'h08, vec, acks);
    n_tests++;
    if (vec !== 8'hE6 || acks !== 1) begin
      $display("FAIL sba_ack: got vec %h acks %0d want vec e6 acks 1", vec, acks);
      n_fail++;
    end
    n_tests++;
    if (bus.req_rd !== 8'h08) begin
      $display("FAIL sba_req_kept: got %h want 08", bus.req_rd); n_fail++;
    end
`ifdef Z80_INTC_NESTING_EN
    eoi_pulse();
    tick(2);
`endif
    n_tests++;
    if (bus.int_n !== 1'b0) begin
      $display("FAIL sba_int_n: got %b want 0", bus.int_n); n_fail++;
    end
    clear_all();
  endtask

  task automatic test_spurious();
    logic [7:0] vec;
    int acks;
    set_ena(8'h01);
    pulse_stb(8'h01);
    tick(1);
    n_tests++;
    if (bus.int_n !== 1'b0) begin
      $display("FAIL spur_asserted: got %b want 0", bus.int_n); n_fail++;
    end
    write_reg(1'b0, 8'h01, 1'b0);
    n_tests++;
    if (bus.int_n !== 1'b0) begin
      $display("FAIL ena_wr_t1: got %b want 0", bus.int_n); n_fail++;
    end
    tick(1);
    n_tests++;
    if (bus.int_n !== 1'b1) begin
      $display("FAIL ena_wr_t2: got %b want 1", bus.int_n); n_fail++;
    end
    iack_cycle(8'h00, vec, acks);
    n_tests++;
    if (vec !== 8'hEE || acks !== 0) begin
      $display("FAIL spur_cycle: got vec %h acks %0d want vec ee acks 0", vec, acks);
      n_fail++;
    end
    n_tests++;
    if (bus.req_rd !== 8'h01) begin
      $display("FAIL spur_req: got %h want 01", bus.req_rd); n_fail++;
    end
    clear_all();
  endtask

`ifdef Z80_INTC_NESTING_EN
  task automatic test_nesting();
    logic [7:0] vec;
    int acks;
    set_ena(8'hFF);
    pulse_stb(8'h20);
    tick(2);
    iack_cycle(8'h00, vec, acks);
    n_tests++;
    if (vec !== 8'hEA || bus.isr_rd !== 8'h20) begin
      $display("FAIL nest_isr5: got vec %h isr %h want vec ea isr 20", vec, bus.isr_rd);
      n_fail++;
    end
    pulse_stb(8'h40);
    tick(2);
    n_tests++;
    if (bus.int_n !== 1'b1) begin
      $display("FAIL nest_low_masked: got %b want 1", bus.int_n); n_fail++;
    end
    pulse_stb(8'h02);
    tick(2);
    n_tests++;
    if (bus.int_n !== 1'b0) begin
      $display("FAIL nest_high_passes: got %b want 0", bus.int_n); n_fail++;
    end
    iack_cycle(8'h00, vec, acks);
    n_tests++;
    if (vec !== 8'hE2 || bus.isr_rd !== 8'h22) begin
      $display("FAIL nest_isr1: got vec %h isr %h want vec e2 isr 22", vec, bus.isr_rd);
      n_fail++;
    end
    eoi_pulse();
    tick(2);
    n_tests++;
    if (bus.isr_rd !== 8'h20 || bus.int_n !== 1'b1) begin
      $display("FAIL nest_eoi1: got isr %h int_n %b want isr 20 int_n 1",
               bus.isr_rd, bus.int_n); n_fail++;
    end
    eoi_pulse();
    tick(2);
    n_tests++;
    if (bus.isr_rd !== 8'h00 || bus.int_n !== 1'b0) begin
      $display("FAIL nest_eoi2: got isr %h int_n %b want isr 00 int_n 0",
               bus.isr_rd, bus.int_n); n_fail++;
    end
    iack_cycle(8'h00, vec, acks);
    n_tests++;
    if (vec !== 8'hEC || acks !== 1) begin
      $display("FAIL nest_ch6: got vec %h acks %0d want vec ec acks 1", vec, acks);
      n_fail++;
    end
    clear_all();
  endtask
`else
  task automatic test_no_nesting();
    logic [7:0] vec;
    int acks;
    set_ena(8'hFF);
    pulse_stb(8'h20);
    tick(2);
    iack_cycle(8'h00, vec, acks);
    n_tests++;
    if (vec !== 8'hEA || bus.isr_rd !== 8'h00) begin
      $display("FAIL flat_isr: got vec %h isr %h want vec ea isr 00", vec, bus.isr_rd);
      n_fail++;
    end
    pulse_stb(8'h40);
    tick(2);
    n_tests++;
    if (bus.int_n !== 1'b0) begin
      $display("FAIL flat_no_mask: got %b want 0", bus.int_n); n_fail++;
    end
    eoi_pulse();
    tick(1);
    n_tests++;
    if (bus.int_n !== 1'b0 || bus.isr_rd !== 8'h00) begin
      $display("FAIL flat_eoi_ignored: got int_n %b isr %h want int_n 0 isr 00",
               bus.int_n, bus.isr_rd); n_fail++;
    end
    iack_cycle(8'h00, vec, acks);
    n_tests++;
    if (vec !== 8'hEC || acks !== 1) begin
      $display("FAIL flat_ch6: got vec %h acks %0d want vec ec acks 1", vec, acks);
      n_fail++;
    end
    clear_all();
  endtask
`endif

  task automatic test_reset_mid_ack();
    int acks;
    set_ena(8'hFF);
    pulse_stb(8'h10);
    tick(2);
    bus.m1_n = 1'b0;
    tick(3);
    bus.iorq_n = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(2);
    test_reset();
    rst = 1'b0;
    tick(1);
    bus.m1_n   = 1'b1;
    bus.iorq_n = 1'b1;
    acks = 0;
    repeat (8) begin
      tick(1);
      if (bus.int_ack) acks++;
    end
    n_tests++;
    if (acks !== 0 || bus.req_rd !== 8'h00) begin
      $display("FAIL rst_mid_ack: got acks %0d req %h want acks 0 req 00",
               acks, bus.req_rd); n_fail++;
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.m1_n     = 1'b1;
    bus.iorq_n   = 1'b1;
    bus.int_stbs = '0;
    bus.wr_mask  = '0;
    bus.wr_val   = 1'b0;
    bus.ena_wr   = 1'b0;
    bus.req_wr   = 1'b0;
    bus.eoi_wr   = 1'b0;
    tick(3);
    test_reset();
    rst = 1'b0;
    tick(1);
    test_basic();
    test_priority();
    test_strobe_beats_ack();
    test_spurious();
`ifdef Z80_INTC_NESTING_EN
    test_nesting();
`else
    test_no_nesting();
`endif
    test_reset_mid_ack();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
